// File: rtl/otter_alu_mdu_if.sv
// Request/response bundle between the OTTER pipeline and the ALU/MDU
// execute unit: START/READY accept handshake, VALID result pulse.
interface otter_alu_mdu_if #(
    parameter int WIDTH = 32
);
    logic             START;
    logic             MD_EN;
    logic [3:0]       ALU_FUN;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             READY;
    logic             VALID;
    logic [WIDTH-1:0] RESULT;

    modport master (
        output START, MD_EN, ALU_FUN, A, B,
        input  READY, VALID, RESULT
    );

    modport slave (
        input  START, MD_EN, ALU_FUN, A, B,
        output READY, VALID, RESULT
    );
endinterface

// File: rtl/otter_alu_mdu.sv
// OTTER execute unit: single-cycle RV32I ALU plus iterative RV32M
// shift-add multiplier and restoring divider sharing one hi/lo register pair.
module otter_alu_mdu #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input logic CLK,
    input logic RST_N,
    otter_alu_mdu_if.slave alu
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t state, state_d;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, mcand, result;
    logic             neg, sel_hi;

    logic ready, accept, busy, last;
    logic [3:0] fun;
    logic md, is_mul, is_div, run_div;
    logic a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf;
    logic [WIDTH-1:0] a_mag, b_mag, alu_res, imm;
    logic [SHW-1:0] sh;

    assign ready  = (state == IDLE) || (state == DONE);
    assign busy   = (state == MUL) || (state == DIV);
    assign accept = alu.START & ready;
    assign last   = cnt == CW'(WIDTH - 1);

    assign alu.READY  = ready;
    assign alu.VALID  = state == DONE;
    assign alu.RESULT = result;

    assign fun = alu.ALU_FUN;
    assign md  = alu.MD_EN;
    assign sh  = alu.B[SHW-1:0];

    assign is_mul = md ? ~fun[2] : (fun == 4'd10);
    assign is_div = md & fun[2];

    // DIV/REM are signed on both sides; MULHSU signs only A
    assign a_sgn = md & (is_div ? ~fun[0] : (fun[1:0] != 2'b11));
    assign b_sgn = md & (is_div ? ~fun[0] : ~fun[1]);
    assign a_neg = a_sgn & alu.A[WIDTH-1];
    assign b_neg = b_sgn & alu.B[WIDTH-1];
    assign a_mag = a_neg ? -alu.A : alu.A;
    assign b_mag = b_neg ? -alu.B : alu.B;

    assign b_zero  = alu.B == '0;
    assign ovf     = is_div & ~fun[0] & (alu.A == MIN) & (alu.B == ONES);
    assign run_div = is_div & ~b_zero & ~ovf;

    always_comb begin
        alu_res = '0;
        case (fun)
            4'd0:    alu_res = alu.A + alu.B;
            4'd8:    alu_res = alu.A - alu.B;
            4'd6:    alu_res = alu.A | alu.B;
            4'd7:    alu_res = alu.A & alu.B;
            4'd4:    alu_res = alu.A ^ alu.B;
            4'd5:    alu_res = alu.A >> sh;
            4'd1:    alu_res = alu.A << sh;
            4'd13:   alu_res = $signed(alu.A) >>> sh;
            4'd2:    alu_res = WIDTH'($signed(alu.A) < $signed(alu.B));
            4'd3:    alu_res = WIDTH'(alu.A < alu.B);
            4'd9:    alu_res = alu.A;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        imm = alu_res;
        if (md) begin
            if (b_zero) imm = fun[1] ? alu.A : ONES;
            else        imm = fun[1] ? '0 : MIN;
        end
    end

    logic [WIDTH:0]     sum, sh_rem, diff;
    logic [WIDTH-1:0]   hi_n, lo_n, pick, pick_s, fin;
    logic [2*WIDTH-1:0] prod, prod_s;

    assign sum    = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
    assign sh_rem = {hi, lo[WIDTH-1]};
    assign diff   = sh_rem - {1'b0, mcand};

    always_comb begin
        hi_n = diff[WIDTH] ? sh_rem[WIDTH-1:0] : diff[WIDTH-1:0];
        lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
        if (state == MUL) begin
            hi_n = sum[WIDTH:1];
            lo_n = {sum[0], lo[WIDTH-1:1]};
        end
    end

    // sign fix-up on the value the final step is about to produce
    assign prod   = {hi_n, lo_n};
    assign prod_s = neg ? -prod : prod;
    assign pick   = sel_hi ? hi_n : lo_n;
    assign pick_s = neg ? -pick : pick;
    assign fin    = (state == DIV) ? pick_s
                  : (sel_hi ? prod_s[2*WIDTH-1:WIDTH] : prod_s[WIDTH-1:0]);

    always_comb begin
        state_d = state;
        case (state)
            IDLE, DONE: begin
                if (!accept)      state_d = IDLE;
                else if (is_mul)  state_d = MUL;
                else if (run_div) state_d = DIV;
                else              state_d = DONE;
            end
            MUL, DIV: if (last) state_d = DONE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            result <= '0;
            neg    <= 1'b0;
            sel_hi <= 1'b0;
        end else if (accept) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= run_div ? a_mag : b_mag;
            mcand  <= run_div ? b_mag : a_mag;
            neg    <= (is_div & fun[1]) ? a_neg : (a_neg ^ b_neg);
            sel_hi <= is_div ? fun[1] : (md & (fun[1:0] != 2'b00));
            if (!is_mul && !run_div) result <= imm;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            hi  <= hi_n;
            lo  <= lo_n;
            if (last) result <= fin;
        end
    end
endmodule

// File: tb/tb_otter_alu_mdu.sv
// Directed and random checks of otter_alu_mdu at WIDTH=32 and WIDTH=8
// against a plain-arithmetic reference model.
module tb_otter_alu_mdu;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   w = 32;
    int   cyc = 0;
    int   vcyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    otter_alu_mdu_if #(.WIDTH(32)) b32 ();
    otter_alu_mdu_if #(.WIDTH(8))  b8 ();

    otter_alu_mdu #(.WIDTH(32)) dut32 (.CLK(clk), .RST_N(rst_n), .alu(b32));
    otter_alu_mdu #(.WIDTH(8))  dut8  (.CLK(clk), .RST_N(rst_n), .alu(b8));

    function automatic logic [31:0] model(int wd, bit md, logic [3:0] fun,
                                          logic [31:0] a, logic [31:0] b);
        longint mask, ua, ub, sa, sb, p, minv;
        int sh;
        mask = (64'sd1 <<< wd) - 1;
        ua = {32'b0, a} & mask;
        ub = {32'b0, b} & mask;
        minv = 64'sd1 <<< (wd - 1);
        sa = (ua >= minv) ? ua - (64'sd1 <<< wd) : ua;
        sb = (ub >= minv) ? ub - (64'sd1 <<< wd) : ub;
        sh = int'(ub % wd);
        if (md) begin
            case (fun[2:0])
                3'd0: p = sa * sb;
                3'd1: p = (sa * sb) >> wd;
                3'd2: p = (sa * ub) >> wd;
                3'd3: p = (ua * ub) >> wd;
                3'd4: p = (ub == 0) ? mask
                        : (sa == -minv && sb == -1) ? ua : sa / sb;
                3'd5: p = (ub == 0) ? mask : ua / ub;
                3'd6: p = (ub == 0) ? ua
                        : (sa == -minv && sb == -1) ? 0 : sa % sb;
                default: p = (ub == 0) ? ua : ua % ub;
            endcase
        end else begin
            case (fun)
                4'd0:    p = ua + ub;
                4'd8:    p = ua - ub;
                4'd6:    p = ua | ub;
                4'd7:    p = ua & ub;
                4'd4:    p = ua ^ ub;
                4'd5:    p = ua >> sh;
                4'd1:    p = ua << sh;
                4'd13:   p = sa >>> sh;
                4'd2:    p = (sa < sb) ? 1 : 0;
                4'd3:    p = (ua < ub) ? 1 : 0;
                4'd9:    p = ua;
                4'd10:   p = ua * ub;
                default: p = 0;
            endcase
        end
        return 32'(p & mask);
    endfunction

    function automatic int model_lat(int wd, bit md, logic [3:0] fun,
                                     logic [31:0] a, logic [31:0] b);
        longint mask, ua, ub;
        mask = (64'sd1 <<< wd) - 1;
        ua = {32'b0, a} & mask;
        ub = {32'b0, b} & mask;
        if (!md) return (fun == 4'd10) ? wd + 1 : 1;
        if (!fun[2]) return wd + 1;
        if (ub == 0) return 1;
        if (!fun[0] && ua == (64'sd1 <<< (wd - 1)) && ub == mask) return 1;
        return wd + 1;
    endfunction

    function automatic logic rdy();
        return (w == 8) ? b8.READY : b32.READY;
    endfunction

    function automatic logic vld();
        return (w == 8) ? b8.VALID : b32.VALID;
    endfunction

    function automatic logic [31:0] res();
        return (w == 8) ? {24'b0, b8.RESULT} : b32.RESULT;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(bit s, bit md, logic [3:0] fun,
                         logic [31:0] a, logic [31:0] b);
        b8.START = 1'b0;
        b32.START = 1'b0;
        if (w == 8) begin
            b8.START = s; b8.MD_EN = md; b8.ALU_FUN = fun;
            b8.A = a[7:0]; b8.B = b[7:0];
        end else begin
            b32.START = s; b32.MD_EN = md; b32.ALU_FUN = fun;
            b32.A = a; b32.B = b;
        end
    endtask

    task automatic run(string tag, bit md, logic [3:0] fun,
                       logic [31:0] a, logic [31:0] b,
                       bit has_dir, logic [31:0] dir);
        int lat;
        int guard;
        int elat;
        bit busy_ok;
        guard = 0;
        busy_ok = 1'b1;
        elat = model_lat(w, md, fun, a, b);
        while (rdy() !== 1'b1 && guard < 100) begin
            @(posedge clk); #1; guard++;
        end
        drive(1'b1, md, fun, a, b);
        @(posedge clk); #1;
        drive(1'b0, md, fun, a, b);
        lat = 1;
        while (vld() !== 1'b1 && lat < 100) begin
            if (rdy() !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        vcyc = cyc;
        chk({tag, " latency"}, lat, elat);
        if (elat > 1) chk({tag, " ready_low"}, 32'(busy_ok), 32'd1);
        chk({tag, " result"}, res(), model(w, md, fun, a, b));
        if (has_dir) chk({tag, " const"}, res(), dir);
    endtask

    initial begin
        int c0;
        int lat;
        bit seen;
        bit busy_ok;
        bit md;
        logic [3:0] fun;
        logic [31:0] a, b, minv, ones;

        w = 32;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        w = 8;
        drive(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
        w = 32;
        #1;
        chk("rst ready", 32'(b32.READY), 32'd1);
        chk("rst valid", 32'(b32.VALID), 32'd0);
        chk("rst result", b32.RESULT, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("add", 0, 4'd0, 32'd5, 32'd7, 1, 32'd12);
        @(posedge clk); #1;
        chk("pulse valid", 32'(b32.VALID), 32'd0);
        chk("hold result", b32.RESULT, 32'd12);

        run("sra", 0, 4'd13, 32'h8000_0000, 32'd4, 1, 32'hF800_0000);
        run("slt", 0, 4'd2, 32'hFFFF_FFFF, 32'd1, 1, 32'd1);
        c0 = vcyc;
        run("sltu", 0, 4'd3, 32'hFFFF_FFFF, 32'd1, 1, 32'd0);
        chk("b2b gap", vcyc - c0, 1);
        run("sll", 0, 4'd1, 32'h0000_0003, 32'h0000_0025, 1, 32'h0000_0060);
        run("bad", 0, 4'd15, 32'h1234_5678, 32'd3, 1, 32'd0);

        run("mulh", 1, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0);
        run("mulhu", 1, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE);
        run("mulhsu", 1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
        run("mul", 1, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h1);
        run("fun10", 0, 4'd10, 32'd6, 32'd7, 1, 32'd42);

        run("div", 1, 4'd4, -32'sd7, 32'd2, 1, 32'hFFFF_FFFD);
        run("rem", 1, 4'd6, -32'sd7, 32'd2, 1, 32'hFFFF_FFFF);
        run("divu", 1, 4'd5, 32'd100, 32'd7, 1, 32'd14);
        run("remu", 1, 4'd7, 32'd100, 32'd7, 1, 32'd2);
        run("divu0", 1, 4'd5, 32'd9, 32'd0, 1, 32'hFFFF_FFFF);
        run("rem0", 1, 4'd6, 32'd9, 32'd0, 1, 32'd9);
        run("divovf", 1, 4'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        run("removf", 1, 4'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);

        // START held high through a MUL must not restart it
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 4'd0, 32'd3, 32'd5);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 4'd0, 32'd7, 32'd9);
        lat = 1;
        busy_ok = 1'b1;
        repeat (10) begin
            if (b32.READY !== 1'b0 || b32.VALID !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1; lat++;
        end
        drive(1'b0, 1'b1, 4'd0, 32'd7, 32'd9);
        while (b32.VALID !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        chk("hold_start busy", 32'(busy_ok), 32'd1);
        chk("hold_start latency", lat, 33);
        chk("hold_start result", b32.RESULT, 32'd15);

        // reset in the middle of a division
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 4'd5, 32'd1000, 32'd3);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 4'd5, 32'd1000, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst ready", 32'(b32.READY), 32'd1);
        chk("mid_rst valid", 32'(b32.VALID), 32'd0);
        chk("mid_rst result", b32.RESULT, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b32.VALID !== 1'b0) seen = 1'b1;
        end
        chk("mid_rst no_valid", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            md = 1'($urandom_range(0, 1));
            fun = md ? {1'b0, 3'($urandom_range(0, 7))} : 4'($urandom_range(0, 15));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 9));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: ;
            endcase
            run($sformatf("rnd32_%0d", i), md, fun, a, b, 0, 32'd0);
        end

        w = 8;
        minv = 32'h80;
        ones = 32'hFF;
        @(posedge clk); #1;
        run("w8_mul", 1, 4'd0, 32'd3, 32'd4, 1, 32'd12);
        run("w8_mulh", 1, 4'd1, 32'h80, 32'h80, 1, 32'h40);
        run("w8_div", 1, 4'd4, 32'hF9, 32'd2, 1, 32'hFD);
        run("w8_ovf", 1, 4'd4, minv, ones, 1, 32'h80);
        for (int i = 0; i < 30; i++) begin
            md = 1'($urandom_range(0, 1));
            fun = md ? {1'b0, 3'($urandom_range(0, 7))} : 4'($urandom_range(0, 15));
            a = 32'($urandom_range(0, 255));
            b = 32'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = minv; b = ones; end
                default: ;
            endcase
            run($sformatf("rnd8_%0d", i), md, fun, a, b, 0, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
